// File: rtl/pulse_conditioner_if.sv
// Channel bus between the pad inputs and the pulse conditioner.
// The master drives the raw pad levels and enable; the slave returns the
// debounced levels and the rising-edge strobes.
interface pulse_conditioner_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] pulse_out;
  logic [WIDTH-1:0] level_out;

  modport master (
    output enable,
    output raw_in,
    input  pulse_out,
    input  level_out
  );

  modport slave (
    input  enable,
    input  raw_in,
    output pulse_out,
    output level_out
  );
endinterface

// File: rtl/pulse_conditioner.sv
// Per-channel pad conditioner: each raw input is synchronised, debounced,
// and turned into a one-cycle strobe on every accepted 0->1 transition.
// The strobe feeds the pulse input of the downstream gray-code counter.
// SYNC_STAGES legal range is 2..3, DEBOUNCE_CYCLES legal range is 1..255.
module pulse_conditioner #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pulse_conditioner_if.slave   bus
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit so
  // the DEBOUNCE_CYCLES = 1 case still elaborates.
  localparam int CNT_W = (DEBOUNCE_CYCLES <= 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] pulse_vec;
  logic [WIDTH-1:0] level_vec;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   sync;

    // Oldest synchroniser stage is the only one the debouncer may look at.
    assign sync = sync_q[SYNC_STAGES-1];

    // Next-state: synchroniser always shifts; debounce/strobe only while enabled.
    always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], bus.raw_in[gi]};
      cnt_d   = cnt_q;
      level_d = level_q;
      pulse_d = 1'b0;
      if (bus.enable) begin
        if (sync == level_q) begin
          // Any return to the accepted level discards a partial count.
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          level_d = sync;
          cnt_d   = '0;
          // Level differs from sync here, so sync = 1 means a 0->1 acceptance.
          pulse_d = sync;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
      end
    end

    assign pulse_vec[gi] = pulse_q;
    assign level_vec[gi] = level_q;
  end

  assign bus.pulse_out = pulse_vec;
  assign bus.level_out = level_vec;

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed bench for pulse_conditioner at default parameters
// (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 -> 6-edge latency).
module tb_pulse_conditioner;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  pulse_conditioner_if #(.WIDTH(WIDTH)) bus ();

  pulse_conditioner #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so outputs are stable.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges, release 1 ns after an edge.
  task automatic do_reset(input logic [WIDTH-1:0] raw);
    bus.raw_in = raw;
    bus.enable = 1'b1;
    rst_n      = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [WIDTH-1:0] exp_p, exp_l;
    bus.raw_in = 8'hFF;
    bus.enable = 1'b1;
    rst_n      = 1'b0;
    tick;
    tick;
    checks++;
    if (bus.pulse_out !== 8'h00) begin
      $display("FAIL reset_pulse: pulse_out=%h expected 00", bus.pulse_out);
      failures++;
    end
    checks++;
    if (bus.level_out !== 8'h00) begin
      $display("FAIL reset_level: level_out=%h expected 00", bus.level_out);
      failures++;
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick;
      exp_p = (e == 6) ? 8'hFF : 8'h00;
      exp_l = (e >= 6) ? 8'hFF : 8'h00;
      checks++;
      if (bus.pulse_out !== exp_p) begin
        $display("FAIL reset_release_pulse edge %0d: pulse_out=%h expected %h", e, bus.pulse_out, exp_p);
        failures++;
      end
      checks++;
      if (bus.level_out !== exp_l) begin
        $display("FAIL reset_release_level edge %0d: level_out=%h expected %h", e, bus.level_out, exp_l);
        failures++;
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_glitch;
    do_reset(8'h00);
    for (int e = 1; e <= 15; e++) begin
      bus.raw_in = (e <= 3) ? 8'h01 : 8'h00;
      tick;
      checks++;
      if (bus.pulse_out !== 8'h00 || bus.level_out !== 8'h00) begin
        $display("FAIL glitch edge %0d: pulse_out=%h level_out=%h expected 00/00", e, bus.pulse_out, bus.level_out);
        failures++;
      end
    end
    $display("test_glitch done");
  endtask

  task automatic test_bounce;
    logic [WIDTH-1:0] exp_p, exp_l;
    do_reset(8'h00);
    // raw[3] before edges 1..4 = 1,0,1,0; stable 1 from edge 5; sync high
    // after edge 6; accepted on edge 10.
    for (int e = 1; e <= 13; e++) begin
      bus.raw_in = ((e >= 5) || (e % 2 == 1)) ? 8'h08 : 8'h00;
      tick;
      exp_p = (e == 10) ? 8'h08 : 8'h00;
      exp_l = (e >= 10) ? 8'h08 : 8'h00;
      checks++;
      if (bus.pulse_out !== exp_p) begin
        $display("FAIL bounce_pulse edge %0d: pulse_out=%h expected %h", e, bus.pulse_out, exp_p);
        failures++;
      end
      checks++;
      if (bus.level_out !== exp_l) begin
        $display("FAIL bounce_level edge %0d: level_out=%h expected %h", e, bus.level_out, exp_l);
        failures++;
      end
    end
    $display("test_bounce done");
  endtask

  task automatic test_fall;
    logic [WIDTH-1:0] exp_l;
    do_reset(8'h00);
    bus.raw_in = 8'h20;
    for (int e = 1; e <= 8; e++) begin
      tick;
      if (e == 6) begin
        checks++;
        if (bus.pulse_out !== 8'h20) begin
          $display("FAIL fall_setup_pulse: pulse_out=%h expected 20", bus.pulse_out);
          failures++;
        end
      end
    end
    bus.raw_in = 8'h00;
    for (int e = 1; e <= 8; e++) begin
      tick;
      exp_l = (e >= 6) ? 8'h00 : 8'h20;
      checks++;
      if (bus.level_out !== exp_l) begin
        $display("FAIL fall_level edge %0d: level_out=%h expected %h", e, bus.level_out, exp_l);
        failures++;
      end
      checks++;
      if (bus.pulse_out !== 8'h00) begin
        $display("FAIL fall_pulse edge %0d: pulse_out=%h expected 00", e, bus.pulse_out);
        failures++;
      end
    end
    $display("test_fall done");
  endtask

  task automatic test_enable;
    do_reset(8'h00);
    bus.raw_in = 8'h02;
    // Edges 3 and 4 bring cnt to 2.
    for (int e = 1; e <= 4; e++) tick;
    bus.enable = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick;
      checks++;
      if (bus.pulse_out !== 8'h00 || bus.level_out !== 8'h00) begin
        $display("FAIL enable_frozen edge %0d: pulse_out=%h level_out=%h expected 00/00", e, bus.pulse_out, bus.level_out);
        failures++;
      end
    end
    bus.enable = 1'b1;
    tick;
    checks++;
    if (bus.pulse_out !== 8'h00 || bus.level_out !== 8'h00) begin
      $display("FAIL enable_resume1: pulse_out=%h level_out=%h expected 00/00", bus.pulse_out, bus.level_out);
      failures++;
    end
    tick;
    checks++;
    if (bus.pulse_out !== 8'h02 || bus.level_out !== 8'h02) begin
      $display("FAIL enable_resume2: pulse_out=%h level_out=%h expected 02/02", bus.pulse_out, bus.level_out);
      failures++;
    end
    tick;
    checks++;
    if (bus.pulse_out !== 8'h00 || bus.level_out !== 8'h02) begin
      $display("FAIL enable_resume3: pulse_out=%h level_out=%h expected 00/02", bus.pulse_out, bus.level_out);
      failures++;
    end
    $display("test_enable done");
  endtask

  task automatic test_async_reset;
    logic [WIDTH-1:0] exp_p, exp_l;
    do_reset(8'h00);
    bus.raw_in = 8'h01;
    for (int e = 1; e <= 7; e++) tick;
    checks++;
    if (bus.level_out !== 8'h01) begin
      $display("FAIL async_setup_level: level_out=%h expected 01", bus.level_out);
      failures++;
    end
    bus.raw_in = 8'h81;
    for (int e = 1; e <= 4; e++) tick;
    // Assert reset between edges; outputs must clear without a clock edge.
    #3;
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.level_out !== 8'h00 || bus.pulse_out !== 8'h00) begin
      $display("FAIL async_clear: level_out=%h pulse_out=%h expected 00/00", bus.level_out, bus.pulse_out);
      failures++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick;
      exp_p = (e == 6) ? 8'h81 : 8'h00;
      exp_l = (e >= 6) ? 8'h81 : 8'h00;
      checks++;
      if (bus.pulse_out !== exp_p) begin
        $display("FAIL async_release_pulse edge %0d: pulse_out=%h expected %h", e, bus.pulse_out, exp_p);
        failures++;
      end
      checks++;
      if (bus.level_out !== exp_l) begin
        $display("FAIL async_release_level edge %0d: level_out=%h expected %h", e, bus.level_out, exp_l);
        failures++;
      end
    end
    $display("test_async_reset done");
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.enable = 1'b1;
    bus.raw_in = '0;
    test_reset;
    test_glitch;
    test_bounce;
    test_fall;
    test_enable;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
